mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 178 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-cache memory arbiter: grants one requester at a time and forwards one read or write to memory.
// Tie-break: ARB_ROUND_ROBIN_EN alternates on ties; when it is undefined, cache 0 always wins a tie.
module mem_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        C0_MRead_request,
  input  logic        C1_MRead_request,
  input  logic        C0_MWrite_request,
  input  logic        C1_MWrite_request,
  input  logic [7:0]  C0_MAddress,
  input  logic [7:0]  C1_MAddress,
  input  logic [7:0]  C0_MWrite_data,
  input  logic [7:0]  C1_MWrite_data,
  output logic [31:0] C0_MRead_data,
  output logic [31:0] C1_MRead_data,
  output logic        C0_MRead_ready,
  output logic        C1_MRead_ready,
  output logic        C0_MWrite_done,
  output logic        C1_MWrite_done,
  output logic        MRead_request,
  output logic        MWrite_request,
  output logic [7:0]  MAddress,
  output logic [7:0]  MWrite_data,
  input  logic [31:0] MRead_data,
  input  logic        MRead_ready,
  input  logic        MWrite_done,
  output logic [1:0]  grant
);

  typedef enum logic [1:0] {IDLE, BUSY, RELEASE} state_t;

  state_t      state_q, state_d;
  logic        win_q, win_d;
  logic        wr_q, wr_d;
  logic [7:0]  addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [1:0]  grant_q, grant_d;
  logic        mrd_q, mrd_d;
  logic        mwr_q, mwr_d;
  logic [31:0] c0_rdata_q, c0_rdata_d;
  logic [31:0] c1_rdata_q, c1_rdata_d;
  logic        c0_rready_q, c0_rready_d;
  logic        c1_rready_q, c1_rready_d;
  logic        c0_wdone_q, c0_wdone_d;
  logic        c1_wdone_q, c1_wdone_d;

  logic c0_act, c1_act, tie_win, win_sel, win_req;

  assign c0_act  = C0_MRead_request | C0_MWrite_request;
  assign c1_act  = C1_MRead_request | C1_MWrite_request;
  assign win_sel = (c0_act && c1_act) ? tie_win : c1_act;
  assign win_req = win_q ? c1_act : c0_act;

`ifdef ARB_ROUND_ROBIN_EN
  // last_q holds the index of the most recent winner; a tie goes to the other cache
  logic last_q, last_d;
  assign tie_win = ~last_q;
`else
  assign tie_win = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    win_d       = win_q;
    wr_d        = wr_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    grant_d     = grant_q;
    mrd_d       = mrd_q;
    mwr_d       = mwr_q;
    c0_rdata_d  = c0_rdata_q;
    c1_rdata_d  = c1_rdata_q;
    c0_rready_d = 1'b0;
    c1_rready_d = 1'b0;
    c0_wdone_d  = 1'b0;
    c1_wdone_d  = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
    last_d      = last_q;
`endif
    case (state_q)
      IDLE: begin
        if (c0_act || c1_act) begin
          win_d   = win_sel;
          wr_d    = win_sel ? C1_MWrite_request : C0_MWrite_request;
          addr_d  = win_sel ? C1_MAddress : C0_MAddress;
          wdata_d = win_sel ? C1_MWrite_data : C0_MWrite_data;
          grant_d = win_sel ? 2'b10 : 2'b01;
          state_d = BUSY;
        end
      end
      BUSY: begin
        // First BUSY cycle has no memory request yet; issue it one cycle after the grant
        if (!mrd_q && !mwr_q) begin
          mrd_d = ~wr_q;
          mwr_d = wr_q;
        end else if (mrd_q && MRead_ready) begin
          mrd_d = 1'b0;
          if (win_q) begin
            c1_rdata_d  = MRead_data;
            c1_rready_d = 1'b1;
          end else begin
            c0_rdata_d  = MRead_data;
            c0_rready_d = 1'b1;
          end
          state_d = RELEASE;
        end else if (mwr_q && MWrite_done) begin
          mwr_d = 1'b0;
          if (win_q) c1_wdone_d = 1'b1;
          else       c0_wdone_d = 1'b1;
          state_d = RELEASE;
        end
      end
      RELEASE: begin
        if (!win_req) begin
          grant_d = 2'b00;
`ifdef ARB_ROUND_ROBIN_EN
          last_d  = win_q;
`endif
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      win_q       <= 1'b0;
      wr_q        <= 1'b0;
      addr_q      <= 8'h00;
      wdata_q     <= 8'h00;
      grant_q     <= 2'b00;
      mrd_q       <= 1'b0;
      mwr_q       <= 1'b0;
      c0_rdata_q  <= 32'h0;
      c1_rdata_q  <= 32'h0;
      c0_rready_q <= 1'b0;
      c1_rready_q <= 1'b0;
      c0_wdone_q  <= 1'b0;
      c1_wdone_q  <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      last_q      <= 1'b1;
`endif
    end else begin
      state_q     <= state_d;
      win_q       <= win_d;
      wr_q        <= wr_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      grant_q     <= grant_d;
      mrd_q       <= mrd_d;
      mwr_q       <= mwr_d;
      c0_rdata_q  <= c0_rdata_d;
      c1_rdata_q  <= c1_rdata_d;
      c0_rready_q <= c0_rready_d;
      c1_rready_q <= c1_rready_d;
      c0_wdone_q  <= c0_wdone_d;
      c1_wdone_q  <= c1_wdone_d;
`ifdef ARB_ROUND_ROBIN_EN
      last_q      <= last_d;
`endif
    end
  end

  assign MRead_request  = mrd_q;
  assign MWrite_request = mwr_q;
  assign MAddress       = addr_q;
  assign MWrite_data    = wdata_q;
  assign grant          = grant_q;
  assign C0_MRead_data  = c0_rdata_q;
  assign C1_MRead_data  = c1_rdata_q;
  assign C0_MRead_ready = c0_rready_q;
  assign C1_MRead_ready = c1_rready_q;
  assign C0_MWrite_done = c0_wdone_q;
  assign C1_MWrite_done = c1_wdone_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed table, multi-cycle corner sequences and random rounds.
// Tie expectations follow ARB_ROUND_ROBIN_EN exactly as the design build does.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        C0_MRead_request, C1_MRead_request, C0_MWrite_request, C1_MWrite_request;
  logic [7:0]  C0_MAddress, C1_MAddress, C0_MWrite_data, C1_MWrite_data;
  logic [31:0] C0_MRead_data, C1_MRead_data;
  logic        C0_MRead_ready, C1_MRead_ready, C0_MWrite_done, C1_MWrite_done;
  logic        MRead_request, MWrite_request;
  logic [7:0]  MAddress, MWrite_data;
  logic [31:0] MRead_data;
  logic        MRead_ready, MWrite_done;
  logic [1:0]  grant;

  int          total = 0;
  int          bad = 0;
  int          model_last;
  logic [31:0] model_rdata [2];

  typedef struct {
    bit         c0_rd, c0_wr, c1_rd, c1_wr;
    logic [7:0] a0, a1, d0, d1;
    logic [31:0] mdata;
    bit         spurious;
    int         exp_win;
    bit         exp_wr;
    logic [7:0] exp_addr, exp_wd;
  } vec_t;

  mem_arbiter dut (
    .clk(clk), .rst(rst),
    .C0_MRead_request(C0_MRead_request), .C1_MRead_request(C1_MRead_request),
    .C0_MWrite_request(C0_MWrite_request), .C1_MWrite_request(C1_MWrite_request),
    .C0_MAddress(C0_MAddress), .C1_MAddress(C1_MAddress),
    .C0_MWrite_data(C0_MWrite_data), .C1_MWrite_data(C1_MWrite_data),
    .C0_MRead_data(C0_MRead_data), .C1_MRead_data(C1_MRead_data),
    .C0_MRead_ready(C0_MRead_ready), .C1_MRead_ready(C1_MRead_ready),
    .C0_MWrite_done(C0_MWrite_done), .C1_MWrite_done(C1_MWrite_done),
    .MRead_request(MRead_request), .MWrite_request(MWrite_request),
    .MAddress(MAddress), .MWrite_data(MWrite_data),
    .MRead_data(MRead_data), .MRead_ready(MRead_ready), .MWrite_done(MWrite_done),
    .grant(grant)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, wanted 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_cache(input int c, input bit rd, input bit wr, input logic [7:0] a, input logic [7:0] d);
    if (c == 0) begin
      C0_MRead_request = rd; C0_MWrite_request = wr; C0_MAddress = a; C0_MWrite_data = d;
    end else begin
      C1_MRead_request = rd; C1_MWrite_request = wr; C1_MAddress = a; C1_MWrite_data = d;
    end
  endtask

  function automatic int tie_winner();
`ifdef ARB_ROUND_ROBIN_EN
    return (model_last == 0) ? 1 : 0;
`else
    return 0;
`endif
  endfunction

  function automatic logic [31:0] pulses();
    return {28'h0, C1_MWrite_done, C1_MRead_ready, C0_MWrite_done, C0_MRead_ready};
  endfunction

  task automatic check_all_zero(input string tag);
    check_output({tag, "_grant"}, 32'(grant), 32'h0);
    check_output({tag, "_mrd_req"}, 32'(MRead_request), 32'h0);
    check_output({tag, "_mwr_req"}, 32'(MWrite_request), 32'h0);
    check_output({tag, "_maddr"}, 32'(MAddress), 32'h0);
    check_output({tag, "_mwdata"}, 32'(MWrite_data), 32'h0);
    check_output({tag, "_c0_rdata"}, C0_MRead_data, 32'h0);
    check_output({tag, "_c1_rdata"}, C1_MRead_data, 32'h0);
    check_output({tag, "_pulses"}, pulses(), 32'h0);
  endtask

  task automatic apply_stimulus_reset();
    rst = 1'b0;
    set_cache(0, 0, 0, 8'h00, 8'h00);
    set_cache(1, 0, 0, 8'h00, 8'h00);
    MRead_ready = 1'b0; MWrite_done = 1'b0; MRead_data = 32'h0;
    tick();
    tick();
    rst = 1'b1;
    model_last = 1;
    model_rdata[0] = 32'h0;
    model_rdata[1] = 32'h0;
  endtask

  task automatic wait_mem_req();
    int n = 0;
    while (!(MRead_request || MWrite_request) && n < 20) begin
      tick();
      n++;
    end
    check_output("mem_req_seen", 32'(MRead_request | MWrite_request), 32'h1);
  endtask

  // One complete granted transaction: checks the issued request, answers it, checks the completion
  task automatic serve(input int w, input bit wr, input logic [7:0] a, input logic [7:0] d,
                       input logic [31:0] mdata, input int delay, input bit spurious);
    wait_mem_req();
    check_output("grant", 32'(grant), (w == 0) ? 32'h1 : 32'h2);
    check_output("mwr_req", 32'(MWrite_request), 32'(wr));
    check_output("mrd_req", 32'(MRead_request), 32'(!wr));
    check_output("maddr", 32'(MAddress), 32'(a));
    if (wr) check_output("mwdata", 32'(MWrite_data), 32'(d));
    repeat (delay) tick();
    check_output("maddr_hold", 32'(MAddress), 32'(a));
    check_output("req_hold", 32'({MRead_request, MWrite_request}), wr ? 32'h1 : 32'h2);
    if (spurious) begin
      if (wr) begin MRead_ready = 1'b1; MRead_data = 32'hBAD0BAD0; end
      else MWrite_done = 1'b1;
      tick();
      MRead_ready = 1'b0; MWrite_done = 1'b0;
      check_output("wrong_type_ignored", pulses(), 32'h0);
      check_output("req_kept", 32'(MRead_request | MWrite_request), 32'h1);
    end
    if (wr) MWrite_done = 1'b1;
    else begin MRead_ready = 1'b1; MRead_data = mdata; end
    tick();
    MRead_ready = 1'b0; MWrite_done = 1'b0; MRead_data = $urandom();
    if (!wr) model_rdata[w] = mdata;
    check_output("done_pulse", pulses(), 32'(1) << (w * 2 + (wr ? 1 : 0)));
    check_output("req_dropped", 32'({MRead_request, MWrite_request}), 32'h0);
    check_output("c0_rdata", C0_MRead_data, model_rdata[0]);
    check_output("c1_rdata", C1_MRead_data, model_rdata[1]);
    set_cache(w, 0, 0, 8'h00, 8'h00);
    tick();
    check_output("pulse_single", pulses(), 32'h0);
    check_output("grant_released", 32'(grant), 32'h0);
    model_last = w;
  endtask

  initial begin
    vec_t        vecs [6];
    logic [1:0]  exp_order [3];
    logic [7:0]  ra [2];
    logic [7:0]  rd [2];
    int          kind [2];
    int          w, first;

    vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h83, 8'h00, 8'h5A, 32'h0,        1'b0, 1, 1'b1, 8'h83, 8'h5A};
    vecs[1] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h20, 8'h00, 8'h77, 8'h00, 32'h0,        1'b0, 0, 1'b1, 8'h20, 8'h77};
    vecs[2] = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h40, 8'h00, 8'h00, 32'h11223344, 1'b0, 1, 1'b0, 8'h40, 8'h00};
    vecs[3] = '{1'b1, 1'b0, 1'b0, 1'b1, 8'h01, 8'hFE, 8'h00, 8'h99, 32'hCAFEF00D, 1'b0, 0, 1'b0, 8'h01, 8'h00};
    vecs[4] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'hAB, 8'h00, 8'hC3, 8'h00, 32'h0,        1'b1, 0, 1'b1, 8'hAB, 8'hC3};
    vecs[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h7F, 8'h00, 8'h00, 8'h00, 32'h80000001, 1'b1, 0, 1'b0, 8'h7F, 8'h00};
`ifdef ARB_ROUND_ROBIN_EN
    exp_order = '{2'b01, 2'b10, 2'b01};
`else
    exp_order = '{2'b01, 2'b01, 2'b01};
`endif

    apply_stimulus_reset();
    rst = 1'b0;
    check_all_zero("reset");
    rst = 1'b1;

    // Cache 0 read of 0x14; memory request must appear exactly one cycle after the grant
    set_cache(0, 1, 0, 8'h14, 8'h00);
    tick();
    check_output("grant_first_edge", 32'(grant), 32'h1);
    check_output("no_req_first_edge", 32'(MRead_request), 32'h0);
    tick();
    check_output("req_second_edge", 32'(MRead_request), 32'h1);
    serve(0, 1'b0, 8'h14, 8'h00, 32'hDDCCBBAA, 2, 1'b0);

    for (int i = 0; i < 6; i++) begin
      set_cache(0, vecs[i].c0_rd, vecs[i].c0_wr, vecs[i].a0, vecs[i].d0);
      set_cache(1, vecs[i].c1_rd, vecs[i].c1_wr, vecs[i].a1, vecs[i].d1);
      tick();
      serve(vecs[i].exp_win, vecs[i].exp_wr, vecs[i].exp_addr, vecs[i].exp_wd, vecs[i].mdata, 1, vecs[i].spurious);
      set_cache(0, 0, 0, 8'h00, 8'h00);
      set_cache(1, 0, 0, 8'h00, 8'h00);
      tick();
      check_output("idle_after_vec", 32'(grant), 32'h0);
    end

    // Reset asserted mid-transaction clears everything at once and abandons the write
    set_cache(1, 0, 1, 8'h55, 8'h66);
    wait_mem_req();
    #2 rst = 1'b0;
    #1 check_all_zero("midreset");
    MWrite_done = 1'b1;
    set_cache(1, 0, 0, 8'h00, 8'h00);
    tick();
    rst = 1'b1;
    model_last = 1;
    model_rdata[0] = 32'h0;
    model_rdata[1] = 32'h0;
    tick();
    tick();
    check_output("no_pulse_after_reset", pulses(), 32'h0);
    check_output("idle_after_reset", 32'(grant), 32'h0);
    MWrite_done = 1'b0;
    set_cache(0, 1, 0, 8'h33, 8'h00);
    tick();
    serve(0, 1'b0, 8'h33, 8'h00, 32'h0BADCAFE, 0, 1'b0);

    // Both caches keep reading; each winner drops only long enough to be released
    apply_stimulus_reset();
    ra[0] = 8'h10; ra[1] = 8'h90;
    set_cache(0, 1, 0, ra[0], 8'h00);
    set_cache(1, 1, 0, ra[1], 8'h00);
    for (int k = 0; k < 3; k++) begin
      w = tie_winner();
      wait_mem_req();
      check_output("tie_order", 32'(grant), 32'(exp_order[k]));
      serve(w, 1'b0, ra[w], 8'h00, 32'hA5000000 + 32'(k), 1, 1'b0);
      if (k < 2) set_cache(w, 1, 0, ra[w], 8'h00);
    end
    set_cache(0, 0, 0, 8'h00, 8'h00);
    set_cache(1, 0, 0, 8'h00, 8'h00);
    tick();
    tick();

    // Random rounds: each cache's pending request is served in the order the tie rule dictates
    apply_stimulus_reset();
    for (int r = 0; r < 40; r++) begin
      kind[0] = int'($urandom_range(0, 3));
      kind[1] = int'($urandom_range(0, 3));
      if (kind[0] == 0 && kind[1] == 0) kind[0] = 1;
      for (int c = 0; c < 2; c++) begin
        ra[c] = 8'($urandom());
        rd[c] = 8'($urandom());
        set_cache(c, kind[c] == 1 || kind[c] == 3, kind[c] >= 2, ra[c], rd[c]);
      end
      tick();
      if (kind[0] != 0 && kind[1] != 0) first = tie_winner();
      else first = (kind[0] != 0) ? 0 : 1;
      serve(first, kind[first] >= 2, ra[first], rd[first], $urandom(),
            int'($urandom_range(0, 3)), $urandom_range(0, 1) == 1);
      if (kind[1 - first] != 0)
        serve(1 - first, kind[1 - first] >= 2, ra[1 - first], rd[1 - first], $urandom(),
              int'($urandom_range(0, 3)), $urandom_range(0, 1) == 1);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
